// File: rtl/uart_pkg.sv
// Shared definitions for the framed UART transmitter: FSM states,
// parity mode codes and the bit-period helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_EVEN = 1;
    localparam int unsigned PAR_ODD  = 2;

    // Clock cycles per serial bit (integer division, truncating).
    function automatic int unsigned calc_bit_period(input int unsigned clock_freq,
                                                    input int unsigned baud_rate);
        return clock_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with show-ahead read: the head word is visible on
// pop_data whenever the FIFO is non-empty. Push when full and pop when empty
// are ignored.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_data,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Next-state for storage, pointers (wrap naturally, DEPTH is 2^PW) and count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Word storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/uart_tx_frame.sv
// Framed UART transmitter: words enter a FIFO over valid/ready and are sent
// back-to-back as start, DATA_BITS data (LSB first), optional parity and
// STOP_BITS stop bits.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          tx_valid,
    input  logic [DATA_BITS-1:0]          tx_data,
    output logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          tx,
    output logic                          tx_busy
);

    localparam int unsigned BIT_PERIOD = calc_bit_period(CLOCK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W      = $clog2(BIT_PERIOD);
    localparam int unsigned IDX_W      = $clog2(DATA_BITS + 1);

    uart_state_e          state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic                 fifo_full, fifo_empty, fifo_pop, fifo_push;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 bit_end;
    logic                 load_word;

    function automatic logic word_parity(input logic [DATA_BITS-1:0] w);
        return (PARITY == PAR_ODD) ? ~(^w) : (^w);
    endfunction

    assign tx_ready  = !reset && !fifo_full;
    assign fifo_push = tx_valid && tx_ready;
    assign tx        = tx_q;
    assign tx_busy   = busy_q;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .push_data (tx_data),
        .pop_data  (fifo_head),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Frame sequencing: bit timing, state transitions and line level.
    // Loading a word is shared by IDLE and the final STOP cycle so that
    // queued frames follow each other with no idle gap.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        fifo_pop   = 1'b0;
        load_word  = 1'b0;
        bit_end    = (clk_cnt_q == CNT_W'(BIT_PERIOD - 1));

        if (state_q != ST_IDLE) begin
            clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    load_word = 1'b1;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
                        if (PARITY != PAR_NONE) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_cnt_d = 1'b0;
                            tx_d       = 1'b1;
                        end
                    end else begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                    tx_d       = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        if (!fifo_empty) begin
                            load_word = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            busy_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load_word) begin
            fifo_pop  = 1'b1;
            shift_d   = fifo_head;
            parity_d  = word_parity(fifo_head);
            clk_cnt_d = '0;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            state_d   = ST_START;
        end
    end

    // State, counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
        end
    end

endmodule
